// File: rtl/bist_pkg.sv
// Shared types and defaults for the BIST responder and its controller.
package bist_pkg;

  // Responder FSM states.
  typedef enum logic [2:0] {
    RS_IDLE  = 3'd0,
    RS_ARMED = 3'd1,
    RS_APPLY = 3'd2,
    RS_GAP   = 3'd3,
    RS_DONE  = 3'd4
  } resp_state_e;

  // Controller (bist state_machine) state encodings, kept here so both ends agree.
  localparam logic [2:0] CTRL_S0 = 3'd0;
  localparam logic [2:0] CTRL_S1 = 3'd1;
  localparam logic [2:0] CTRL_S2 = 3'd2;
  localparam logic [2:0] CTRL_S3 = 3'd3;
  localparam logic [2:0] CTRL_S4 = 3'd4;
  localparam logic [2:0] CTRL_S5 = 3'd5;

  // Default pattern/signature polynomials and seeds.
  localparam int         DEF_WIDTH     = 16;
  localparam int         DEF_CNT_W     = 16;
  localparam logic [15:0] DEF_LFSR_POLY = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] DEF_MISR_POLY = 16'hB400;
  localparam logic [15:0] DEF_MISR_SEED = 16'h0000;

  // States in which patterns may be applied or the run finished.
  function automatic logic is_active(resp_state_e s);
    return (s == RS_ARMED) || (s == RS_APPLY) || (s == RS_GAP);
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Right-shifting Galois LFSR with a parallel data input; din=0 gives a pattern
// generator, din=response gives a MISR.
module bist_lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  // Next state: seed reload wins over a shift step.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed;
    end else if (en) begin
      q_d = (q_q >> 1) ^ (q_q[0] ? POLY : '0) ^ din;
    end
  end

  // Register; reset value is the seed.
  always_ff @(posedge clock) begin
    if (reset) q_q <= seed;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/bist_responder.sv
// Pattern/response end of the BIST handshake: LFSR patterns out, MISR
// compaction of CUT responses, final signature compare and protocol checks.
module bist_responder
  import bist_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(DEF_LFSR_POLY),
  parameter logic [WIDTH-1:0] LFSR_SEED = WIDTH'(DEF_LFSR_SEED),
  parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'(DEF_MISR_POLY),
  parameter logic [WIDTH-1:0] MISR_SEED = WIDTH'(DEF_MISR_SEED),
  parameter int               CNT_W     = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init,
  input  logic             mode,
  input  logic             running,
  input  logic             finish,
  input  logic             bist_end,
  input  logic [WIDTH-1:0] cut_response,
  input  logic [WIDTH-1:0] golden_sig,
  output logic [WIDTH-1:0] pattern,
  output logic [CNT_W-1:0] pattern_count,
  output logic [WIDTH-1:0] signature,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             proto_err,
  output resp_state_e      dbg_state_o
);

  // Handshake: init > finish > mode. A shift step happens only for mode=1 in
  // ARMED/APPLY/GAP with neither init nor finish present in the same cycle.

  resp_state_e      state_q;
  logic [CNT_W-1:0] count_q;
  logic             done_q, pass_q, fail_q, perr_q;
  logic             end_seen_q;
  logic             active;
  logic             step;
  logic [WIDTH-1:0] pat_q, sig_q;

  assign active = is_active(state_q);
  assign step   = mode && !init && !finish && active;

  bist_lfsr #(.WIDTH(WIDTH), .POLY(LFSR_POLY)) u_pattern (
    .clock (clock),
    .reset (reset),
    .load  (init),
    .seed  (LFSR_SEED),
    .en    (step),
    .din   ('0),
    .q     (pat_q)
  );

  bist_lfsr #(.WIDTH(WIDTH), .POLY(MISR_POLY)) u_misr (
    .clock (clock),
    .reset (reset),
    .load  (init),
    .seed  (MISR_SEED),
    .en    (step),
    .din   (cut_response),
    .q     (sig_q)
  );

  // FSM, pattern counter, signature compare and sticky protocol checks.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RS_IDLE;
      count_q    <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      perr_q     <= 1'b0;
      end_seen_q <= 1'b0;
    end else begin
      // bist_end may lead DONE by one cycle; a second early cycle is an error.
      end_seen_q <= bist_end && (state_q != RS_DONE);
      if (bist_end && (state_q != RS_DONE) && end_seen_q) perr_q <= 1'b1;

      if (init) begin
        state_q <= RS_ARMED;
        count_q <= '0;
        done_q  <= 1'b0;
        pass_q  <= 1'b0;
        fail_q  <= 1'b0;
        if ((state_q == RS_APPLY) || (state_q == RS_GAP)) perr_q <= 1'b1;
      end else if (finish) begin
        if (active) begin
          state_q <= RS_DONE;
          done_q  <= 1'b1;
          pass_q  <= (sig_q == golden_sig);
          fail_q  <= (sig_q != golden_sig);
        end else begin
          perr_q <= 1'b1;
        end
        if (mode) perr_q <= 1'b1;
      end else if (mode) begin
        if (active) begin
          state_q <= RS_APPLY;
          if (count_q != {CNT_W{1'b1}}) count_q <= count_q + CNT_W'(1);
        end else begin
          perr_q <= 1'b1;
        end
      end else if ((state_q == RS_APPLY) && running) begin
        state_q <= RS_GAP;
      end
    end
  end

  assign pattern       = pat_q;
  assign signature     = sig_q;
  assign pattern_count = count_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail          = fail_q;
  assign proto_err     = perr_q;
  assign dbg_state_o   = state_q;

endmodule
